alu_nibble_sequencer: RTL and testbench



---
 rtl/alu_nibble_sequencer.sv | 81 ++++++++
 tb/tb_alu_nibble_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives one 4-bit 74181-style slice a nibble per clock and
// assembles the WIDTH-bit result, returned on a valid/ready response channel.
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_s,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_c_in,
  output logic [3:0]       alu_s,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_c_in,
  input  logic [3:0]       alu_f,
  input  logic             alu_c_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_c_out
);
  localparam int NNIB = WIDTH / 4;
  localparam int IW = NNIB > 1 ? $clog2(NNIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [3:0]       s_q;
  logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
  logic             c_q, co_q, last;
  // Operands shift right so the active nibble is always at [3:0] and drains to zero by DONE.
  assign last = idx_q == IW'(NNIB - 1);
  assign f_d = (f_q >> 4) | (WIDTH'(alu_f) << (WIDTH - 4));
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rsp_f = f_q;
  assign rsp_c_out = co_q;
  assign alu_s = s_q;
  assign alu_a = a_q[3:0];
  assign alu_b = b_q[3:0];
  assign alu_c_in = c_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
      c_q <= 1'b0;
      co_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          s_q <= req_s;
          a_q <= req_a;
          b_q <= req_b;
          c_q <= req_c_in;
          idx_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          f_q <= f_d;
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          c_q <= last ? 1'b0 : alu_c_out;
          s_q <= last ? 4'h0 : s_q;
          idx_q <= last ? '0 : idx_q + IW'(1);
          if (last) begin
            co_q <= alu_c_out;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: drives the sequencer against a behavioural 4-bit slice
// and checks results against a full-width arithmetic reference model.
module tb_alu_nibble_sequencer;
  localparam int WIDTH = 16;
  localparam int NNIB = WIDTH / 4;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_c_in = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_s = '0;
  logic [WIDTH-1:0] req_a = '0, req_b = '0;
  logic req_ready, alu_c_in, alu_c_out, rsp_valid, rsp_c_out;
  logic [3:0] alu_s, alu_a, alu_b, alu_f;
  logic [WIDTH-1:0] rsp_f;
  logic [4:0] slice_r;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_c_out(rsp_c_out)
  );

  // External slice: a few 74181 active-high arithmetic modes, XOR for everything else
  always_comb begin
    case (alu_s)
      4'b1001: slice_r = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_c_in);
      4'b0110: slice_r = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_c_in);
      4'b1100: slice_r = {1'b0, alu_a} + {1'b0, alu_a} + 5'(alu_c_in);
      4'b0000: slice_r = {1'b0, alu_a} + 5'(alu_c_in);
      default: slice_r = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_f = slice_r[3:0];
  assign alu_c_out = slice_r[4];

  function automatic logic [WIDTH:0] model(input logic [3:0] s, input logic [WIDTH-1:0] a, b, input logic c);
    logic [WIDTH:0] ax, cx;
    ax = {1'b0, a};
    cx = (WIDTH + 1)'(c);
    case (s)
      4'b1001: return ax + {1'b0, b} + cx;
      4'b0110: return ax + {1'b0, ~b} + cx;
      4'b1100: return ax + ax + cx;
      4'b0000: return ax + cx;
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  task automatic issue(input logic [3:0] s, input logic [WIDTH-1:0] a, b, input logic c, input bit scramble,
                       output bit acc, output logic [WIDTH-1:0] sa, sb, ss, output logic [NNIB-1:0] sc,
                       output bit early, output logic vld, output logic [WIDTH-1:0] f, output logic co);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_s = s; req_a = a; req_b = b; req_c_in = c;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    early = 1'b0;
    for (int k = 0; k < NNIB; k++) begin
      sa[4*k+:4] = alu_a;
      sb[4*k+:4] = alu_b;
      ss[4*k+:4] = alu_s;
      sc[k] = alu_c_in;
      early |= rsp_valid;
      if (scramble) begin
        req_a = WIDTH'($urandom);
        req_b = WIDTH'($urandom);
        req_s = 4'($urandom);
        req_c_in = 1'($urandom);
      end
      @(negedge clk);
    end
    vld = rsp_valid; f = rsp_f; co = rsp_c_out;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_f, rsp_c_out} !== '0) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0", rsp_f, rsp_c_out); end
    checks++; if ({alu_s, alu_a, alu_b, alu_c_in} !== '0) begin failures++; $display("FAIL reset_alu got=%h%h%h%b exp=0", alu_s, alu_a, alu_b, alu_c_in); end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    bit acc, early;
    logic [WIDTH-1:0] sa, sb, ss, f;
    logic [NNIB-1:0] sc;
    logic vld, co;
    issue(4'b1001, 16'h1234, 16'h0FFF, 1'b0, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL add1_accept got=%b exp=1", acc); end
    checks++; if (early !== 1'b0 || vld !== 1'b1) begin failures++; $display("FAIL add1_latency early=%b valid=%b exp=0/1", early, vld); end
    checks++; if (f !== 16'h2233 || co !== 1'b0) begin failures++; $display("FAIL add1_result got=%h/%b exp=2233/0", f, co); end
    checks++; if (sa !== 16'h1234 || sb !== 16'h0FFF) begin failures++; $display("FAIL add1_nibbles a=%h b=%h exp=1234/0fff", sa, sb); end
    checks++; if (ss !== 16'h9999) begin failures++; $display("FAIL add1_sel got=%h exp=9999", ss); end
    checks++; if (alu_a !== 4'h0 || alu_s !== 4'h0 || alu_c_in !== 1'b0) begin failures++; $display("FAIL done_alu_zero got=%h/%h/%b exp=0", alu_s, alu_a, alu_c_in); end
    release_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL add1_idle ready=%b valid=%b exp=1/0", req_ready, rsp_valid); end
    checks++; if (rsp_f !== 16'h2233) begin failures++; $display("FAIL idle_hold got=%h exp=2233", rsp_f); end
    issue(4'b1001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
    checks++; if (f !== 16'h0000 || co !== 1'b1) begin failures++; $display("FAIL add2_result got=%h/%b exp=0000/1", f, co); end
    checks++; if (sc !== 4'b1110) begin failures++; $display("FAIL add2_carry_seq got=%b exp=1110", sc); end
    release_rsp();
    issue(4'b0110, 16'h0005, 16'h0007, 1'b1, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
    checks++; if (f !== 16'hFFFE || co !== 1'b0) begin failures++; $display("FAIL sub1_result got=%h/%b exp=fffe/0", f, co); end
    release_rsp();
    issue(4'b0110, 16'h0007, 16'h0005, 1'b1, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
    checks++; if (f !== 16'h0002 || co !== 1'b1) begin failures++; $display("FAIL sub2_result got=%h/%b exp=0002/1", f, co); end
    release_rsp();
  endtask

  task automatic test_backpressure();
    bit acc, early;
    logic [WIDTH-1:0] sa, sb, ss, f;
    logic [NNIB-1:0] sc;
    logic vld, co;
    logic [WIDTH:0] e1, e2;
    e1 = model(4'b1001, 16'hA5C3, 16'h1E2F, 1'b1);
    e2 = model(4'b0110, 16'h3000, 16'h4001, 1'b0);
    issue(4'b1001, 16'hA5C3, 16'h1E2F, 1'b1, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
    req_valid = 1'b1; req_s = 4'b0110; req_a = 16'h3000; req_b = 16'h4001; req_c_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_c_out, rsp_f} !== e1 || req_ready !== 1'b0)
        begin failures++; $display("FAIL bp_hold cyc=%0d valid=%b rsp=%b/%h ready=%b exp=1 %h 0", i, rsp_valid, rsp_c_out, rsp_f, req_ready, e1); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h1 || alu_s !== 4'b0110) begin failures++; $display("FAIL bp_second_accept ready=%b a=%h b=%h s=%b exp=0/0/1/0110", req_ready, alu_a, alu_b, alu_s); end
    repeat (NNIB) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || {rsp_c_out, rsp_f} !== e2) begin failures++; $display("FAIL bp_second_result valid=%b got=%b/%h exp=%h", rsp_valid, rsp_c_out, rsp_f, e2); end
    release_rsp();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    int n;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_s = 4'b1001; req_a = 16'h7777; req_b = 16'h8888; req_c_in = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_run_state ready=%b valid=%b exp=1/0", req_ready, rsp_valid); end
    checks++; if ({alu_s, alu_a, alu_b, alu_c_in} !== '0) begin failures++; $display("FAIL rst_run_alu got=%h%h%h%b exp=0", alu_s, alu_a, alu_b, alu_c_in); end
    checks++; if ({rsp_f, rsp_c_out} !== '0) begin failures++; $display("FAIL rst_run_rsp got=%h/%b exp=0", rsp_f, rsp_c_out); end
    for (int i = 0; i < 12; i++) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_run_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_stability();
    bit acc, early;
    logic [WIDTH-1:0] sa, sb, ss, f, a, b;
    logic [NNIB-1:0] sc;
    logic vld, co;
    logic [WIDTH:0] e;
    for (int i = 0; i < 4; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      e = model(4'b1001, a, b, i[0]);
      issue(4'b1001, a, b, i[0], 1'b1, acc, sa, sb, ss, sc, early, vld, f, co);
      checks++; if ({co, f} !== e || sa !== a || sb !== b) begin failures++; $display("FAIL stable_result got=%b/%h a=%h b=%h exp=%h a=%h b=%h", co, f, sa, sb, e, a, b); end
      release_rsp();
    end
  endtask

  task automatic test_random();
    bit acc, early;
    logic [WIDTH-1:0] sa, sb, ss, f, a, b;
    logic [NNIB-1:0] sc;
    logic [3:0] s;
    logic [3:0] ops [5];
    logic vld, co, c;
    logic [WIDTH:0] e;
    ops = '{4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b0011};
    for (int i = 0; i < 25; i++) begin
      s = ops[$urandom_range(0, 4)];
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      c = 1'($urandom);
      e = model(s, a, b, c);
      issue(s, a, b, c, 1'b0, acc, sa, sb, ss, sc, early, vld, f, co);
      checks++; if (acc !== 1'b1 || vld !== 1'b1 || early !== 1'b0) begin failures++; $display("FAIL rand_handshake i=%0d acc=%b valid=%b early=%b", i, acc, vld, early); end
      checks++; if ({co, f} !== e) begin failures++; $display("FAIL rand_result i=%0d s=%b a=%h b=%h c=%b got=%b/%h exp=%h", i, s, a, b, c, co, f, e); end
      checks++; if (sa !== a || sb !== b || sc[0] !== c || ss !== {NNIB{s}}) begin failures++; $display("FAIL rand_drive i=%0d a=%h b=%h c0=%b s=%h", i, sa, sb, sc[0], ss); end
      release_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_stability();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
